// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: 4-digit multiplexed display scanner with a frame-atomic BCD load path (1-deep pending buffer).
// Optional macro FND_LEADING_ZERO_BLANK_EN blanks leading zero digits; digit 0 always stays lit.
module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_bcd,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [1:0]  o_site_Selection,
    output logic [3:0]  o_fnd_digit,
    output logic [3:0]  o_digit_value,
    output logic        o_frame_done
);
    localparam int unsigned   PW        = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic [3:0]    fnd_q, fnd_d;
    logic [3:0]    val_q, val_d;
    logic          done_q, done_d;
    logic          tick, boundary, accept, blank;

    assign tick     = (presc_q == PRESC_MAX);
    assign boundary = tick && (idx_q == 2'd3);
    assign accept   = i_valid && !pend_full_q;

    always_comb begin
        presc_d     = tick ? '0 : presc_q + PW'(1);
        idx_d       = tick ? idx_q + 2'd1 : idx_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        done_d      = boundary;
        // Transfer tests the old full flag, so a load accepted on the boundary waits a whole frame.
        if (boundary && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (accept) begin
            pend_d      = i_bcd;
            pend_full_d = 1'b1;
        end
    end

    // Anode and value are computed from next-state so they register in step with the index.
    always_comb begin
        blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
        case (idx_d)
            2'd1:    blank = (disp_d[15:4] == 12'd0);
            2'd2:    blank = (disp_d[15:8] == 8'd0);
            2'd3:    blank = (disp_d[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
`endif
        fnd_d = blank ? 4'hF : ~(4'b0001 << idx_d);
        case (idx_d)
            2'd0:    val_d = disp_d[3:0];
            2'd1:    val_d = disp_d[7:4];
            2'd2:    val_d = disp_d[11:8];
            default: val_d = disp_d[15:12];
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            presc_q     <= '0;
            idx_q       <= 2'd0;
            disp_q      <= 16'h0000;
            pend_q      <= 16'h0000;
            pend_full_q <= 1'b0;
            fnd_q       <= 4'b1110;
            val_q       <= 4'h0;
            done_q      <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            idx_q       <= idx_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            fnd_q       <= fnd_d;
            val_q       <= val_d;
            done_q      <= done_d;
        end
    end

    assign o_ready          = !pend_full_q;
    assign o_site_Selection = idx_q;
    assign o_fnd_digit      = fnd_q;
    assign o_digit_value    = val_q;
    assign o_frame_done     = done_q;
endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Bench for fnd_scan_ctrl with SCAN_DIV=4; reference is a cycle-count model of the scan plus a frame-level load buffer.
module tb_fnd_scan_ctrl;
    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] i_bcd = 16'h0000;
    logic        i_valid = 1'b0;
    logic        o_ready, o_frame_done;
    logic [1:0]  o_site_Selection;
    logic [3:0]  o_fnd_digit, o_digit_value;

    int total = 0;
    int bad   = 0;

    // Reference state: edges since reset release, shown value, pending buffer.
    int          n = 0;
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_pend = 16'h0000;
    bit          m_full = 1'b0;

    fnd_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_bcd(i_bcd), .i_valid(i_valid),
        .o_ready(o_ready), .o_site_Selection(o_site_Selection), .o_fnd_digit(o_fnd_digit),
        .o_digit_value(o_digit_value), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    function automatic int exp_idx();
        return (n / DIV) % 4;
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] d, input int k);
        return d[4*k +: 4];
    endfunction

    function automatic logic [3:0] exp_fnd();
        int k;
        logic [3:0] one;
        logic [3:0] r;
        k   = exp_idx();
        one = 4'b0001;
        r   = ~(one << k);
`ifdef FND_LEADING_ZERO_BLANK_EN
        if (k > 0 && (m_disp >> (4 * k)) == 16'd0) r = 4'hF;
`endif
        return r;
    endfunction

    task automatic step(input bit rst, input bit vld, input logic [15:0] bcd);
        bit acc;
        i_reset = rst;
        i_valid = vld;
        i_bcd   = bcd;
        acc     = vld && !m_full && !rst;
        @(posedge i_clk);
        if (rst) begin
            n = 0; m_disp = 16'h0000; m_full = 1'b0;
        end else begin
            n++;
            if (n % FRAME == 0 && m_full) begin
                m_disp = m_pend;
                m_full = 1'b0;
            end
            if (acc) begin
                m_pend = bcd;
                m_full = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle_until(input int target);
        while (n < target) step(0, 0, 16'h0000);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 16'hFFFF);
        total += 5;
        if (o_site_Selection !== 2'd0) begin bad++; $display("FAIL reset_sel got=%b exp=00", o_site_Selection); end
        if (o_fnd_digit !== 4'b1110) begin bad++; $display("FAIL reset_fnd got=%b exp=1110", o_fnd_digit); end
        if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        if (o_digit_value !== 4'h0) begin bad++; $display("FAIL reset_val got=%h exp=0", o_digit_value); end
        if (o_frame_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", o_frame_done); end
        for (int i = 1; i <= 4; i++) begin
            logic [1:0] e;
            step(0, 0, 16'h0000);
            e = (i == 4) ? 2'd1 : 2'd0;
            total++;
            if (o_site_Selection !== e) begin bad++; $display("FAIL release_sel cyc=%0d got=%b exp=%b", i, o_site_Selection, e); end
        end
    endtask

    task automatic test_scan();
        int pulses;
        pulses = 0;
        step(1, 0, 16'h0000);
        for (int i = 0; i < FRAME; i++) begin
            step(0, 0, 16'h0000);
            if (o_frame_done === 1'b1) pulses++;
            total += 2;
            if (o_site_Selection !== 2'(exp_idx())) begin bad++; $display("FAIL scan_sel n=%0d got=%b exp=%0d", n, o_site_Selection, exp_idx()); end
            if (o_fnd_digit !== exp_fnd()) begin bad++; $display("FAIL scan_fnd n=%0d got=%b exp=%b", n, o_fnd_digit, exp_fnd()); end
        end
        total += 2;
        if (pulses != 1) begin bad++; $display("FAIL scan_pulses got=%0d exp=1", pulses); end
        if (o_frame_done !== 1'b1) begin bad++; $display("FAIL scan_done_at_wrap got=%b exp=1", o_frame_done); end
    endtask

    task automatic test_atomic_load();
        logic [15:0] d;
        d = 16'h1234;
        step(1, 0, 16'h0000);
        idle_until(5);
        step(0, 1, d);
        total++;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL load_ready_low got=%b exp=0", o_ready); end
        while (n < FRAME) begin
            total++;
            if (o_digit_value !== 4'h0) begin bad++; $display("FAIL load_old_frame n=%0d got=%h exp=0", n, o_digit_value); end
            step(0, 0, 16'h0000);
        end
        for (int i = 0; i < FRAME; i++) begin
            total += 2;
            if (o_digit_value !== nib(d, exp_idx())) begin bad++; $display("FAIL load_new_frame n=%0d got=%h exp=%h", n, o_digit_value, nib(d, exp_idx())); end
            if (o_ready !== 1'b1) begin bad++; $display("FAIL load_ready_back n=%0d got=%b exp=1", n, o_ready); end
            step(0, 0, 16'h0000);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] d;
        d = 16'h1234;
        step(1, 0, 16'h0000);
        idle_until(2);
        step(0, 1, d);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 16'h5678);
            total++;
            if (o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready n=%0d got=%b exp=0", n, o_ready); end
        end
        idle_until(2 * FRAME);
        for (int i = 0; i < FRAME; i++) begin
            total++;
            if (o_digit_value !== nib(d, exp_idx())) begin bad++; $display("FAIL bp_value n=%0d got=%h exp=%h", n, o_digit_value, nib(d, exp_idx())); end
            step(0, 0, 16'h0000);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] d_old, d_new;
        d_old = 16'h1234;
        d_new = 16'h9999;
        step(1, 0, 16'h0000);
        step(0, 1, d_old);
        idle_until(2 * FRAME - 1);
        step(0, 1, d_new);
        total += 2;
        if (o_ready !== 1'b0) begin bad++; $display("FAIL sim_accepted got=%b exp=0", o_ready); end
        if (o_frame_done !== 1'b1) begin bad++; $display("FAIL sim_boundary got=%b exp=1", o_frame_done); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            logic [3:0] e;
            e = (i < FRAME) ? nib(d_old, exp_idx()) : nib(d_new, exp_idx());
            total++;
            if (o_digit_value !== e) begin bad++; $display("FAIL sim_value n=%0d got=%h exp=%h", n, o_digit_value, e); end
            step(0, 0, 16'h0000);
        end
    endtask

    task automatic test_blank();
        logic [15:0] vals [2];
        vals[0] = 16'h0040;
        vals[1] = 16'h0000;
        step(1, 0, 16'h0000);
        for (int v = 0; v < 2; v++) begin
            step(0, 1, vals[v]);
            idle_until((n / FRAME + 1) * FRAME);
            for (int i = 0; i < FRAME; i++) begin
                logic [3:0] e;
                logic [3:0] one;
                int         k;
                k   = exp_idx();
                one = 4'b0001;
                e   = ~(one << k);
`ifdef FND_LEADING_ZERO_BLANK_EN
                if (vals[v] == 16'h0040 && k >= 2) e = 4'hF;
                if (vals[v] == 16'h0000 && k >= 1) e = 4'hF;
`endif
                total++;
                if (o_fnd_digit !== e) begin bad++; $display("FAIL blank_fnd val=%h idx=%0d got=%b exp=%b", vals[v], k, o_fnd_digit, e); end
                step(0, 0, 16'h0000);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 700; i++) begin
            bit rst;
            rst = ($urandom_range(0, 59) == 0);
            step(rst, ($urandom_range(0, 1) == 1), 16'($urandom));
            total += 5;
            if (o_site_Selection !== 2'(exp_idx())) begin bad++; $display("FAIL rnd_sel n=%0d got=%b exp=%0d", n, o_site_Selection, exp_idx()); end
            if (o_fnd_digit !== exp_fnd()) begin bad++; $display("FAIL rnd_fnd n=%0d got=%b exp=%b", n, o_fnd_digit, exp_fnd()); end
            if (o_digit_value !== nib(m_disp, exp_idx())) begin bad++; $display("FAIL rnd_val n=%0d got=%h exp=%h", n, o_digit_value, nib(m_disp, exp_idx())); end
            if (o_ready !== !m_full) begin bad++; $display("FAIL rnd_ready n=%0d got=%b exp=%b", n, o_ready, !m_full); end
            if (o_frame_done !== (n > 0 && n % FRAME == 0)) begin bad++; $display("FAIL rnd_done n=%0d got=%b exp=%b", n, o_frame_done, (n > 0 && n % FRAME == 0)); end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_atomic_load();
        test_backpressure();
        test_simultaneous();
        test_blank();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
